load_counter_ctrl: RTL and testbench

Sequencer for the 5-bit loadable up-counter. On `start` it loads a start value into the counter, enables counting until the counter output equals a programmed end value, then pulses `done`. It supports pause, abort and auto-repeat. It sits beside the counter and drives that counter's `load`, `count_permission` and `load_data` inputs. It observes the counter's `contagem` output as feedback.

---
 rtl/load_counter_ctrl_if.sv | 36 +++
 rtl/load_counter_ctrl.sv | 152 +++++++++++++++
 tb/tb_load_counter_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_counter_ctrl_if.sv
// Bus between the load_counter_ctrl sequencer and its surroundings: run
// requests and parameters in, counter control and status out, plus the
// counter value fed back from the loadable counter.
interface load_counter_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             start_i;
    logic             abort_i;
    logic             pause_i;
    logic             repeat_mode_i;
    logic [WIDTH-1:0] start_value_i;
    logic [WIDTH-1:0] end_value_i;
    logic [WIDTH-1:0] contagem_i;
    logic             load_o;
    logic             count_permission_o;
    logic [WIDTH-1:0] load_data_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] steps_o;

    // Side that issues runs and owns the counter (system / testbench).
    modport master (
        output start_i, abort_i, pause_i, repeat_mode_i,
        output start_value_i, end_value_i, contagem_i,
        input  load_o, count_permission_o, load_data_o,
        input  busy_o, done_o, steps_o
    );

    // The sequencer itself.
    modport slave (
        input  start_i, abort_i, pause_i, repeat_mode_i,
        input  start_value_i, end_value_i, contagem_i,
        output load_o, count_permission_o, load_data_o,
        output busy_o, done_o, steps_o
    );
endinterface

// File: rtl/load_counter_ctrl.sv
// Sequencer for a loadable up-counter: loads a start value, lets the counter
// run until it matches the latched end value, then pulses done. Supports
// pause, abort and auto-repeat. clear_i is a synchronous active-high reset.
module load_counter_ctrl #(
    parameter int WIDTH = 5
) (
    input logic                 clk_i,
    input logic                 clear_i,
    load_counter_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] start_val_q;
    logic [WIDTH-1:0] start_val_d;
    logic [WIDTH-1:0] end_val_q;
    logic [WIDTH-1:0] end_val_d;
    logic             repeat_q;
    logic             repeat_d;
    logic [WIDTH-1:0] steps_q;
    logic [WIDTH-1:0] steps_d;

    logic             at_end_s;
    logic             load_s;
    logic             count_perm_s;
    logic             busy_s;
    logic             done_s;

    // Terminal match against the end value captured at start.
    assign at_end_s = (bus.contagem_i == end_val_q);

    // State and run-parameter registers; clear overrides everything.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q     <= ST_IDLE;
            start_val_q <= {WIDTH{1'b0}};
            end_val_q   <= {WIDTH{1'b0}};
            repeat_q    <= 1'b0;
            steps_q     <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            start_val_q <= start_val_d;
            end_val_q   <= end_val_d;
            repeat_q    <= repeat_d;
            steps_q     <= steps_d;
        end
    end

    // Next-state logic; abort beats both the terminal match and repeat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (at_end_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_DONE: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (repeat_q) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch run parameters on an accepted start; track increments issued.
    always_comb begin
        start_val_d = start_val_q;
        end_val_d   = end_val_q;
        repeat_d    = repeat_q;
        steps_d     = steps_q;
        if ((state_q == ST_IDLE) && bus.start_i) begin
            start_val_d = bus.start_value_i;
            end_val_d   = bus.end_value_i;
            repeat_d    = bus.repeat_mode_i;
        end else if (state_q == ST_LOAD) begin
            steps_d = {WIDTH{1'b0}};
        end else if (count_perm_s) begin
            steps_d = steps_q + WIDTH'(1);
        end else begin
            steps_d = steps_q;
        end
    end

    // Output decode from state, latched values and counter feedback.
    always_comb begin
        load_s       = 1'b0;
        count_perm_s = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_LOAD: begin
                load_s = 1'b1;
                busy_s = 1'b1;
            end
            ST_COUNT: begin
                count_perm_s = ~bus.pause_i & ~at_end_s;
                busy_s       = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.load_o             = load_s;
    assign bus.count_permission_o = count_perm_s;
    assign bus.busy_o             = busy_s;
    assign bus.done_o             = done_s;
    assign bus.load_data_o        = start_val_q;
    assign bus.steps_o            = steps_q;

endmodule

// File: tb/tb_load_counter_ctrl.sv
// Bench for load_counter_ctrl: a behavioural 5-bit loadable counter closes
// the loop; directed runs from a table, hand-written corner sequences, and a
// randomized phase checked against a run-level reference model.
module tb_load_counter_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         clear = 1'b1;
    logic [W-1:0] cnt = 5'd0;
    int           n_vec = 0;
    int           n_fail = 0;

    load_counter_ctrl_if #(.WIDTH(W)) bus ();

    load_counter_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .clear_i (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Environment: the loadable up-counter the sequencer drives.
    always @(posedge clk) begin
        if (bus.load_o) cnt <= bus.load_data_o;
        else if (bus.count_permission_o) cnt <= cnt + 5'd1;
    end
    assign bus.contagem_i = cnt;

    typedef struct {
        logic [W-1:0] sv;
        logic [W-1:0] ev;
        int           exp_steps;
        int           exp_done;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.pause_i = 1'b0;
        bus.repeat_mode_i = 1'b0;
        bus.start_value_i = 5'd0;
        bus.end_value_i = 5'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // One non-repeating run from the table; done cycle counted from the start edge.
    task automatic run_vec(input int i);
        int found;
        do_clear();
        bus.start_i = 1'b1;
        bus.start_value_i = tbl[i].sv;
        bus.end_value_i = tbl[i].ev;
        step();
        bus.start_i = 1'b0;
        bus.start_value_i = 5'(~tbl[i].sv);
        bus.end_value_i = 5'(tbl[i].sv);
        chk("tbl_load_cycle0", int'(bus.load_o), 1);
        found = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (bus.done_o) begin
                found = k;
                break;
            end
        end
        chk("tbl_done_cycle", found, tbl[i].exp_done);
        chk("tbl_steps", int'(bus.steps_o), tbl[i].exp_steps);
        chk("tbl_contagem_end", int'(cnt), int'(tbl[i].ev));
        step();
        chk("tbl_busy_after", int'(bus.busy_o), 0);
    endtask

    // Reference model: run phase plus the arithmetic distance to the end value.
    typedef enum {P_IDLE, P_LOAD, P_COUNT, P_DONE} phase_t;
    phase_t       m_phase;
    logic [W-1:0] m_sv, m_ev, m_steps;
    logic         m_rep;

    initial begin
        int found, saved, rem, e_cp;
        tbl[0] = '{5'd3,  5'd10, 7,  9};
        tbl[1] = '{5'd30, 5'd2,  4,  6};
        tbl[2] = '{5'd17, 5'd17, 0,  2};
        tbl[3] = '{5'd0,  5'd31, 31, 33};
        tbl[4] = '{5'd31, 5'd0,  1,  3};
        tbl[5] = '{5'd5,  5'd4,  31, 33};

        idle_inputs();
        step();
        step();
        chk("rst_load", int'(bus.load_o), 0);
        chk("rst_cp", int'(bus.count_permission_o), 0);
        chk("rst_load_data", int'(bus.load_data_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_steps", int'(bus.steps_o), 0);
        clear = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Pause held three cycles mid-count: completion slips by three.
        do_clear();
        bus.start_i = 1'b1;
        bus.start_value_i = 5'd0;
        bus.end_value_i = 5'd5;
        found = -1;
        saved = 0;
        for (int k = 0; k <= 14; k++) begin
            step();
            bus.start_i = 1'b0;
            bus.pause_i = (k >= 3 && k <= 5);
            #1;
            if (k == 3) saved = int'(cnt);
            if (bus.pause_i) chk("pause_cp", int'(bus.count_permission_o), 0);
            if (k == 6) chk("pause_hold", int'(cnt), saved);
            if (bus.done_o && found < 0) found = k;
        end
        bus.pause_i = 1'b0;
        chk("pause_done_cycle", found, 10);
        chk("pause_steps", int'(bus.steps_o), 5);

        // Repeat 4..6: done every five cycles, abort during third count.
        do_clear();
        bus.start_i = 1'b1;
        bus.start_value_i = 5'd4;
        bus.end_value_i = 5'd6;
        bus.repeat_mode_i = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            bus.start_i = 1'b0;
            bus.repeat_mode_i = 1'b0;
            bus.abort_i = (k == 12);
            #1;
            chk("rep_done", int'(bus.done_o), int'(k == 4 || k == 9));
            chk("rep_load", int'(bus.load_o), int'(k == 0 || k == 5 || k == 10));
            chk("rep_busy", int'(bus.busy_o), int'(k < 13));
        end
        bus.abort_i = 1'b0;

        // Clear mid-count with start high; start taken on the cycle after.
        do_clear();
        bus.start_i = 1'b1;
        bus.start_value_i = 5'd0;
        bus.end_value_i = 5'd20;
        found = -1;
        for (int k = 0; k <= 20; k++) begin
            step();
            bus.start_i = (k == 5 || k == 6);
            clear = (k == 5);
            if (k == 5) begin
                bus.start_value_i = 5'd7;
                bus.end_value_i = 5'd9;
            end
            #1;
            if (k == 6) begin
                chk("clr_load", int'(bus.load_o), 0);
                chk("clr_cp", int'(bus.count_permission_o), 0);
                chk("clr_load_data", int'(bus.load_data_o), 0);
                chk("clr_busy", int'(bus.busy_o), 0);
                chk("clr_done", int'(bus.done_o), 0);
                chk("clr_steps", int'(bus.steps_o), 0);
            end
            if (k == 7) begin
                chk("clr_restart_load", int'(bus.load_o), 1);
                chk("clr_restart_data", int'(bus.load_data_o), 7);
            end
            if (bus.done_o && found < 0 && k > 6) found = k;
        end
        chk("clr_done_cycle", found, 11);
        chk("clr_steps_end", int'(bus.steps_o), 2);

        // Randomized phase against the reference model.
        idle_inputs();
        do_clear();
        m_phase = P_IDLE;
        m_sv = 5'd0; m_ev = 5'd0; m_rep = 1'b0; m_steps = 5'd0;
        for (int c = 0; c < 3000; c++) begin
            clear = ($urandom_range(0, 99) < 2);
            bus.start_i = ($urandom_range(0, 99) < 30);
            bus.abort_i = ($urandom_range(0, 99) < 3);
            bus.pause_i = ($urandom_range(0, 99) < 25);
            bus.repeat_mode_i = ($urandom_range(0, 99) < 40);
            bus.start_value_i = 5'($urandom_range(0, 31));
            bus.end_value_i = ($urandom_range(0, 3) == 0) ? bus.start_value_i + 5'($urandom_range(0, 3))
                                                          : 5'($urandom_range(0, 31));
            #1;
            rem = (int'(m_ev) - int'(cnt) + 32) % 32;
            e_cp = int'(m_phase == P_COUNT && !bus.pause_i && rem != 0);
            chk("rnd_load", int'(bus.load_o), int'(m_phase == P_LOAD));
            chk("rnd_cp", int'(bus.count_permission_o), e_cp);
            chk("rnd_busy", int'(bus.busy_o), int'(m_phase != P_IDLE));
            chk("rnd_done", int'(bus.done_o), int'(m_phase == P_DONE));
            chk("rnd_load_data", int'(bus.load_data_o), int'(m_sv));
            chk("rnd_steps", int'(bus.steps_o), int'(m_steps));
            if (clear) begin
                m_phase = P_IDLE;
                m_sv = 5'd0; m_ev = 5'd0; m_rep = 1'b0; m_steps = 5'd0;
            end else begin
                case (m_phase)
                    P_IDLE: if (bus.start_i) begin
                        m_sv = bus.start_value_i;
                        m_ev = bus.end_value_i;
                        m_rep = bus.repeat_mode_i;
                        m_phase = P_LOAD;
                    end
                    P_LOAD: begin
                        m_steps = 5'd0;
                        m_phase = bus.abort_i ? P_IDLE : P_COUNT;
                    end
                    P_COUNT: begin
                        if (e_cp != 0) m_steps = 5'((int'(m_steps) + 1) % 32);
                        if (bus.abort_i) m_phase = P_IDLE;
                        else if (rem == 0) m_phase = P_DONE;
                    end
                    default: m_phase = bus.abort_i ? P_IDLE : (m_rep ? P_LOAD : P_IDLE);
                endcase
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
